// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Requester-side bundle for ram_port_arbiter. Carries two
//               request/acknowledge channels and the shared read-data return.
// Revision    : 1.0  initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    // requester 0 channel
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;

    // requester 1 channel
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;

    // shared return path
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    // requester side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata, busy
    );

    // arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter/sequencer sharing one single-port RAM
//               (combinational read, clocked write) between two requesters.
//               Each access takes IDLE -> GRANTx -> ACK; read data is
//               registered at the end of the GRANT cycle.
// Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    ram_port_arbiter_if.slave          bus,
    output logic      [ADDR_WIDTH-1:0] ram_addr,
    output logic      [DATA_WIDTH-1:0] ram_data,
    output logic                       ram_we,
    input  wire logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    // 1 = requester 1 was served last, so requester 0 wins the next tie
    logic                  r_last_served;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_in_grant;
    logic                  w_sel;
    logic                  w_we_sel;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;

    assign w_in_grant = (r_state == S_GRANT0) || (r_state == S_GRANT1);
    assign w_sel      = (r_state == S_GRANT1);

    // Winner's access fields, selected by which grant state is active
    always_comb begin
        w_we_sel    = bus.we0;
        w_addr_sel  = bus.addr0;
        w_wdata_sel = bus.wdata0;
        if (w_sel) begin
            w_we_sel    = bus.we1;
            w_addr_sel  = bus.addr1;
            w_wdata_sel = bus.wdata1;
        end
    end

    // Next-state logic: round-robin pick in IDLE, fixed GRANT -> ACK -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_next_state = r_last_served ? S_GRANT0 : S_GRANT1;
                end else if (bus.req0) begin
                    w_next_state = S_GRANT0;
                end else if (bus.req1) begin
                    w_next_state = S_GRANT1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_GRANT0: w_next_state = S_ACK;
            S_GRANT1: w_next_state = S_ACK;
            S_ACK:    w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember who owned the port last, updated as a grant closes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_served <= 1'b1;
        end else if (w_in_grant) begin
            r_last_served <= w_sel;
        end
    end

    // Acks are set by the closing grant edge, so they are high only in ACK
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
        end else begin
            r_ack0 <= (r_state == S_GRANT0);
            r_ack1 <= (r_state == S_GRANT1);
        end
    end

    // Capture RAM output at the end of a read grant; writes leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_in_grant && !w_we_sel) begin
            r_rdata <= ram_q;
        end
    end

    // RAM pins are driven only during the grant cycle; reset blocks the write
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_we   = 1'b0;
        if (w_in_grant) begin
            ram_addr = w_addr_sel;
            ram_data = w_wdata_sel;
            ram_we   = w_we_sel & ~reset;
        end
    end

    assign bus.ack0  = r_ack0;
    assign bus.ack1  = r_ack1;
    assign bus.rdata = r_rdata;
    assign bus.busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter with a behavioural
//               RAM, a slot-scheduling reference model, a directed vector
//               table, corner-case sequences and randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          ram_we;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    // behavioural single-port RAM: combinational read, clocked write
    logic [DW-1:0] mem [64];
    assign ram_q = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

    function automatic logic [7:0] preload(input logic [5:0] a);
        if (a == 6'h2A) return 8'h7E;
        return {2'b10, a} ^ 8'h0F;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: access-slot scheduling ----------------
    // An accepted request occupies the port for slot g_cycle (RAM access)
    // and g_cycle+1 (ack); the port is free again from g_cycle+2.
    int            cyc = 0;
    int            g_cycle = -10;
    int            g_who = 0;
    logic          g_we = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0;
    int            ls = 1;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] ref_mem [64];
    bit            m_ack0 = 1'b0;
    bit            m_ack1 = 1'b0;
    int            ack_q[$];

    // one clock cycle: check outputs mid-cycle, then advance the model
    task automatic cycle();
        bit in_grant, in_ack;
        int win;
        @(negedge clk);
        in_grant = (cyc == g_cycle);
        in_ack   = (cyc == g_cycle + 1);
        m_ack0   = in_ack && (g_who == 0);
        m_ack1   = in_ack && (g_who == 1);
        chk("busy",   bus.busy, in_grant || in_ack);
        chk("ack0",   bus.ack0, m_ack0);
        chk("ack1",   bus.ack1, m_ack1);
        chk("rdata",  bus.rdata, exp_rdata);
        chk("ram_we", ram_we, in_grant && g_we && !reset);
        if (in_grant) begin
            chk("ram_addr", ram_addr, g_addr);
            if (g_we) chk("ram_data", ram_data, g_wdata);
        end else begin
            chk("ram_addr_idle", ram_addr, 0);
            chk("ram_data_idle", ram_data, 0);
        end
        if (bus.ack0) ack_q.push_back(0);
        if (bus.ack1) ack_q.push_back(1);
        if (reset) begin
            g_cycle   = -10;
            ls        = 1;
            exp_rdata = '0;
        end else if (in_grant) begin
            if (g_we) ref_mem[g_addr] = g_wdata;
            else      exp_rdata = ref_mem[g_addr];
            ls = g_who;
        end else if (!in_ack && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) win = (ls == 1) ? 0 : 1;
            else                      win = bus.req0 ? 0 : 1;
            g_who   = win;
            g_cycle = cyc + 1;
            g_we    = win ? bus.we1    : bus.we0;
            g_addr  = win ? bus.addr1  : bus.addr0;
            g_wdata = win ? bus.wdata1 : bus.wdata0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            who;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic do_access(input vec_t v, input string tag);
        bit seen;
        seen = 1'b0;
        if (v.who == 0) begin
            bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (k == 1 && (v.who ? bus.ack1 : bus.ack0)) seen = 1'b1;
        end
        chk({tag, "_ack_seen"}, seen, 1);
        chk({tag, "_rdata"}, bus.rdata, v.exp_rdata);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // both requesters keep asking, each dropping for one cycle after its ack
    task automatic both_phase(input int n);
        bus.we0 = 1'b1; bus.addr0 = 6'h01; bus.wdata0 = 8'hC3;
        bus.we1 = 1'b0; bus.addr1 = 6'h01; bus.wdata1 = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.req0 = !m_ack0;
            bus.req1 = !m_ack1;
            cycle();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     <= preload(6'(i));
            ref_mem[i]  = preload(6'(i));
        end
        tbl[0] = '{0, 1, 6'h05, 8'hA5, 8'h00};
        tbl[1] = '{1, 0, 6'h05, 8'h00, 8'hA5};
        tbl[2] = '{1, 1, 6'h20, 8'h5A, 8'hA5};
        tbl[3] = '{0, 0, 6'h20, 8'h00, 8'h5A};
        tbl[4] = '{0, 0, 6'h2A, 8'h00, 8'h7E};
        tbl[5] = '{1, 1, 6'h2A, 8'h11, 8'h7E};
        tbl[6] = '{1, 0, 6'h2A, 8'h00, 8'h11};
        tbl[7] = '{0, 0, 6'h3F, 8'h00, 8'hB0};

        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

        // reset state
        do_reset();
        chk("reset_busy",  bus.busy, 0);
        chk("reset_ack",   {bus.ack0, bus.ack1}, 0);
        chk("reset_rdata", bus.rdata, 0);

        // directed table
        for (int i = 0; i < 8; i++) do_access(tbl[i], $sformatf("tbl%0d", i));
        cycle();

        // fairness: both continuously requesting after reset -> 0,1,0,1
        do_reset();
        ack_q.delete();
        both_phase(13);
        chk("rr_count", ack_q.size(), 4);
        for (int i = 0; i < ack_q.size() && i < 4; i++) chk("rr_order", ack_q[i], i % 2);

        // tie right after requester 1 was served goes to requester 0
        do_reset();
        do_access('{1, 0, 6'h03, 8'h00, preload(6'h03)}, "pre_tie");
        cycle();
        ack_q.delete();
        both_phase(6);
        chk("tie_count", ack_q.size(), 2);
        if (ack_q.size() > 0) chk("tie_first", ack_q[0], 0);

        // reset during the GRANT cycle of a write
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h10; bus.wdata0 = 8'h3C;
        cycle();                  // IDLE, request seen
        reset = 1'b1;
        cycle();                  // GRANT with reset high: no write
        reset = 1'b0;
        bus.req0 = 1'b0;
        cycle();
        chk("abort_busy",  bus.busy, 0);
        chk("abort_ack",   {bus.ack0, bus.ack1}, 0);
        chk("abort_rdata", bus.rdata, 0);
        chk("abort_mem",   mem[6'h10], preload(6'h10));
        do_access('{1, 0, 6'h10, 8'h00, preload(6'h10)}, "abort_read");
        cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m_ack0) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'($urandom);
                bus.addr0 = 6'($urandom_range(0, 7)); bus.wdata0 = 8'($urandom);
            end
            if (m_ack1) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.we1 = 1'($urandom);
                bus.addr1 = 6'($urandom_range(0, 7)); bus.wdata1 = 8'($urandom);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the team's single-port RAM (combinational read, write on clock edge). It lets two independent masters, such as a datapath and a display/DMA engine, share the one RAM port. It uses a request/acknowledge handshake, round-robin fairness and a registered read-data return. It sits directly between the requesters and the RAM's data/addr/we/q pins.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 6, RAM address width
- clk  in  1  rising-edge clock, shared with the RAM
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request, level, held until ack
- we0, we1  in  1 each  1 = write, 0 = read; stable while req high
- addr0, addr1  in  ADDR_WIDTH each  access address; stable while req high
- wdata0, wdata1  in  DATA_WIDTH each  write data; stable while req high
- ack0, ack1  out  1 each  one-cycle completion pulse to the served requester
- rdata  out  DATA_WIDTH  registered read data, valid while the matching ack is high
- busy  out  1  high whenever state ≠ IDLE
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_data  out  DATA_WIDTH  to RAM data
- ram_we  out  1  to RAM we
- ram_q  in  DATA_WIDTH  from RAM q

## Operation
- FSM states: IDLE, GRANT0, GRANT1, ACK.
- IDLE:
  - only req0 high → GRANT0; only req1 high → GRANT1.
  - Both high → grant the requester not in last_served.
  - Neither high → stay in IDLE.
- GRANT0 / GRANT1 (exactly one cycle, the RAM access cycle):
  - ram_addr/ram_data/ram_we driven combinationally from the winner's addr/wdata/we.
  - ram_we = we_sel & ~reset.
  - At the closing edge: if read, rdata ← ram_q; if write, rdata holds its prior value.
  - Also at the closing edge: last_served ← winner; next state ACK.
- ACK (one cycle): ack of the served requester = 1, other ack = 0; next state IDLE unconditionally.
- Outside GRANT states: ram_addr = 0, ram_data = 0, ram_we = 0.
- Requester rule:
  - Deassert req in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1…; no requester waits more than one other access.
- Reset values: state IDLE, ack0 = ack1 = 0, rdata = 0, busy = 0, last_served = 1 (requester 0 wins the first tie).
- Reset mid-operation:
  - reset high during GRANT suppresses ram_we in that cycle (RAM contents unchanged).
  - No ack is issued for the aborted access; the FSM returns to IDLE.
- Write followed by read of the same address (either requester) returns the written value.

## Timing
- Request sampled in IDLE at edge E0 → GRANT in cycle E0+1 → ack high in cycle E0+2.
- Latency is 2 cycles from req seen in IDLE to ack.
- Throughput is 1 access per 3 cycles (IDLE, GRANT, ACK).
- rdata changes only at the edge closing a GRANT read cycle; it stays stable through ACK and afterwards until the next read.
- ack0 and ack1 are never high in the same cycle; ack is never high outside ACK.
- busy is combinational from state and goes high the cycle after the request is accepted.
- All outputs except ram_addr, ram_data, ram_we and busy are registered.

## Test plan
- Reset, then req0 = 1, we0 = 1, addr0 = 6'h05, wdata0 = 8'hA5 → ram_we = 1 in exactly one cycle with ram_addr = 05, ram_data = A5. ack0 pulses 2 cycles after req is seen; ack1 stays 0.
- req1 read addr1 = 6'h05 after the write above → ack1 pulse with rdata = 8'hA5; ram_we = 0 throughout.
- req0 and req1 both rise in the same cycle and are held, each dropping for one cycle after its ack → grant order 0,1,0,1 after reset; ack pulses are 3 cycles apart with no cycle where both acks are high.
- Simultaneous requests immediately after requester 1 was served → requester 0 granted first (last_served = 1).
- Write request to addr 6'h10 with wdata 8'h3C, reset asserted during the GRANT cycle → no ram_we pulse, no ack. Reading 6'h10 afterwards returns its original preload contents; all outputs read reset values.
- Read of an address preloaded with 8'h7E, then a write → rdata stays 8'h7E after the write's ack.
